obi_addr_mux: RTL
=================

Name: obi_addr_mux

Overview:
- Parametrised 1-master to N-slave OBI address decoder and response router for the core data port.
- Generalised successor of the fixed system data-bus mux. Slave count, address map and outstanding depth are set by parameters.
- Adds in-order outstanding-transaction tracking, a built-in decode-error responder, and a protocol-violation flag.
- Sits between the cv32e40p data port and RAM/IO/UART/mtimer-class slaves.

Parameters:
- N_SLV, 4, number of slave channels (1..8).
- AW, 32, address width.
- DW, 32, data width (byte enables are DW/8).
- MAX_OUT, 2, maximum outstanding accepted-but-unanswered transactions (1..8).
- SLV_BASE, all zero, packed N_SLV*AW base addresses; slave i occupies bits [i*AW +: AW].
- SLV_MASK, all zero, packed N_SLV*AW compare masks.
- ERR_RDATA, 32'hBADC0DE5, read data returned on decode error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  1  master request.
- m_gnt  out  1  master grant.
- m_addr  in  AW  master address.
- m_we  in  1  write enable.
- m_be  in  DW/8  byte enables.
- m_wdata  in  DW  write data.
- m_rvalid  out  1  response valid.
- m_rdata  out  DW  response data.
- m_err  out  1  response is a decode error.
- s_req  out  N_SLV  per-slave request.
- s_gnt  in  N_SLV  per-slave grant.
- s_addr  out  AW  shared address, equal to m_addr.
- s_we  out  1  shared write enable.
- s_be  out  DW/8  shared byte enables.
- s_wdata  out  DW  shared write data.
- s_rvalid  in  N_SLV  per-slave response valid.
- s_rdata  in  N_SLV*DW  packed per-slave read data.
- err_cnt  out  16  saturating count of decode errors.
- proto_err  out  1  sticky flag: rvalid received from a slave that has nothing outstanding.

Behaviour:
- Decode (combinational): hit[i] = ((m_addr & MASK_i) == (BASE_i & MASK_i)). The lowest index with a hit wins. No hit selects the internal ERR target.
- Tracking FIFO: MAX_OUT entries, each holding the target index (N_SLV values plus ERR). Pointers wrap modulo MAX_OUT. A separate count gives full and empty.
- Switch stall: if the FIFO is non-empty and the decoded target differs from the target of the most recent push, the request is held. Both s_req and m_gnt stay 0 until the FIFO drains. This guarantees in-order responses.
- Forwarding: s_req[sel] = m_req & !full & !stall. All other s_req bits are 0. For an ERR target, no s_req is driven.
- Grant: m_gnt = s_req[sel] & s_gnt[sel]. For an ERR target, m_gnt = m_req & !full & !stall.
- Push: on m_req & m_gnt, the target is pushed at the clock edge.
- Full: when the FIFO is full, no push is allowed even if a pop occurs in the same cycle. m_gnt is 0 that cycle.
- Response from a slave: when the FIFO head is slave k, m_rvalid = s_rvalid[k], m_rdata = s_rdata[k*DW +: DW], m_err = 0.
- Response for a decode error: when the head is ERR, m_rvalid = 1 on every cycle the head is ERR, m_rdata = ERR_RDATA, m_err = 1. Minimum latency is 1 cycle after the grant.
- Pop: on m_rvalid. Push and pop in the same cycle are allowed when the FIFO is not full; the count is unchanged.
- FIFO empty: m_rvalid = 0, m_rdata = 0, m_err = 0.
- Stray responses: s_rvalid[j] asserted while j is not the head target is ignored and not forwarded. It sets proto_err, which stays set until reset.
- err_cnt increments on each ERR push and saturates at 16'hFFFF.
- Shared outputs s_addr, s_we, s_be, s_wdata pass m_* through combinationally.
- Reset (async assert, sync release): FIFO empty, pointers 0, err_cnt = 0, proto_err = 0. Therefore m_rvalid = 0, m_gnt = 0 and s_req = 0 while rst_n is low.
- Reset mid-transaction drops all outstanding entries. Later slave responses to the dropped requests set proto_err.

Test Plan:
- Single read to slave 1, with BASE1 = 32'h0001_0000, MASK1 = 32'hFFFF_0000, addr 32'h0001_0004, slave grants immediately and responds 2 cycles later with 32'h1234_5678 -> m_gnt in cycle 0; m_rvalid = 1, m_rdata = 32'h1234_5678, m_err = 0 in cycle 2; FIFO empty afterwards.
- Read to unmapped addr 32'hF000_0000 -> m_gnt in the same cycle; next cycle m_rvalid = 1, m_rdata = 32'hBADC0DE5, m_err = 1; err_cnt = 1; no s_req asserted.
- MAX_OUT = 2, back-to-back requests to slave 0 with responses delayed 5 cycles -> two grants, third request held (m_gnt = 0) until the first rvalid; responses returned in order.
- Request to slave 0, then immediately to slave 2 while slave 0's response is pending -> slave 2 request stalled (s_req[2] = 0) until slave 0's rvalid; then granted.
- Inject s_rvalid[3] with nothing outstanding -> m_rvalid stays 0; proto_err = 1 and stays 1; pulse rst_n low -> proto_err = 0 and err_cnt = 0.
- Issue 70000 unmapped accesses -> err_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/obi_addr_mux.sv
// 1-master to N-slave OBI address decoder with in-order response routing,
// a built-in decode-error responder and a stray-response (protocol) flag.
module obi_addr_mux #(
  parameter int                  N_SLV     = 4,
  parameter int                  AW        = 32,
  parameter int                  DW        = 32,
  parameter int                  MAX_OUT   = 2,
  parameter logic [N_SLV*AW-1:0] SLV_BASE  = '0,
  parameter logic [N_SLV*AW-1:0] SLV_MASK  = '0,
  parameter logic [DW-1:0]       ERR_RDATA = 32'hBADC0DE5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m_req,
  output logic                m_gnt,
  input  logic [AW-1:0]       m_addr,
  input  logic                m_we,
  input  logic [DW/8-1:0]     m_be,
  input  logic [DW-1:0]       m_wdata,
  output logic                m_rvalid,
  output logic [DW-1:0]       m_rdata,
  output logic                m_err,
  output logic [N_SLV-1:0]    s_req,
  input  logic [N_SLV-1:0]    s_gnt,
  output logic [AW-1:0]       s_addr,
  output logic                s_we,
  output logic [DW/8-1:0]     s_be,
  output logic [DW-1:0]       s_wdata,
  input  logic [N_SLV-1:0]    s_rvalid,
  input  logic [N_SLV*DW-1:0] s_rdata,
  output logic [15:0]         err_cnt,
  output logic                proto_err
);

  localparam int TW = $clog2(N_SLV + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [TW-1:0] ERR_IDX = TW'(N_SLV);

  logic [TW-1:0] r_fifo [MAX_OUT];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_last;
  logic [15:0]   r_err_cnt;
  logic          r_proto;

  logic [TW-1:0] w_sel, w_head;
  logic          w_full, w_nonempty, w_stall, w_fwd;
  logic          w_push, w_pop, w_stray;

  assign s_addr  = m_addr;
  assign s_we    = m_we;
  assign s_be    = m_be;
  assign s_wdata = m_wdata;

  assign err_cnt   = r_err_cnt;
  assign proto_err = r_proto;

  // Descending scan so the lowest-index hit is the last (winning) assignment.
  always_comb begin
    w_sel = ERR_IDX;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))
        w_sel = TW'(i);
    end
  end

  assign w_nonempty = (r_cnt != '0);
  assign w_full     = (r_cnt == CW'(MAX_OUT));
  assign w_head     = r_fifo[r_rd_ptr];
  // Hold a target switch until the FIFO drains so responses can never reorder.
  assign w_stall    = w_nonempty && (w_sel != r_last);
  assign w_fwd      = m_req && rst_n && !w_full && !w_stall;

  always_comb begin
    s_req = '0;
    for (int i = 0; i < N_SLV; i++)
      s_req[i] = w_fwd && (w_sel == TW'(i));
    m_gnt = (w_sel == ERR_IDX) ? w_fwd : |(s_req & s_gnt);
  end

  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_err    = 1'b0;
    w_stray  = 1'b0;
    if (w_nonempty && (w_head == ERR_IDX)) begin
      m_rvalid = 1'b1;
      m_rdata  = ERR_RDATA;
      m_err    = 1'b1;
    end
    for (int i = 0; i < N_SLV; i++) begin
      if (w_nonempty && (w_head == TW'(i))) begin
        m_rvalid = s_rvalid[i];
        m_rdata  = s_rdata[i*DW +: DW];
      end else if (s_rvalid[i]) begin
        w_stray = 1'b1;
      end
    end
  end

  assign w_push = m_req && m_gnt;
  assign w_pop  = m_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUT; i++) r_fifo[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_last    <= '0;
      r_err_cnt <= '0;
      r_proto   <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_last           <= w_sel;
        r_wr_ptr         <= (r_wr_ptr == PW'(MAX_OUT - 1)) ? '0 : r_wr_ptr + PW'(1);
        if ((w_sel == ERR_IDX) && (r_err_cnt != 16'hFFFF))
          r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PW'(MAX_OUT - 1)) ? '0 : r_rd_ptr + PW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - CW'(1);
      if (w_stray)
        r_proto <= 1'b1;
    end
  end

endmodule
